switch_ddf_ms: RTL and testbench

Multi-stream dynamic-dataflow SWITCH actor, the routing dual of the PICK (select/merge) actor. It has one tagged data input and one tagged control input, each buffered per flux. Per flux, it consumes one data token and one control token together and forwards the data token, tag preserved, to output 0 or output 1 as chosen by the control token. It sits between a producer actor and two consumer actors in the multi-flux dataflow fabric.

---
 rtl/ddf_ms_pkg.sv | 36 +++
 rtl/ms_tag_fifo.sv | 67 ++++++
 rtl/switch_ddf_ms.sv | 140 ++++++++++++++
 tb/tb_switch_ddf_ms.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddf_ms_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddf_ms_pkg
// Description : Shared definitions for the multi-stream dataflow actors.
//               Token layout is {tag, payload}. The tag occupies the MSBs.
//               Helpers are provided to locate the token fields and to
//               advance a round-robin index.
// Revision    : 1.0 - initial release
// ============================================================================
package ddf_ms_pkg;

  // Payload always starts at bit 0 of a token.
  localparam int unsigned C_PAYLOAD_LSB = 0;

  // Control payload bit that selects the SWITCH output.
  localparam int unsigned C_SEL_BIT = 0;

  function automatic int unsigned payload_msb(input int unsigned dw);
    return dw - 1;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned tag_msb(input int unsigned dw, input int unsigned tw);
    return dw + tw - 1;
  endfunction

  // Next round-robin index, wrapping to 0 after n-1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ms_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ms_tag_fifo
// Description : Single-flux synchronous FIFO. Full and empty come from a
//               registered occupancy count. A write while full is dropped,
//               even when a read happens in the same cycle.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               wr_en/wr_data - push strobe and token
//               full          - count == DEPTH
//               rd_en/rd_data - pop strobe and head token (show-ahead)
//               empty         - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module ms_tag_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [C_PTR_W:0] C_FULL_CNT = (C_PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W:0]   r_count;
  logic               w_wr;
  logic               w_rd;

  assign full    = (r_count == C_FULL_CNT);
  assign empty   = (r_count == '0);
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; clearing the count is what discards the tokens.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/switch_ddf_ms.sv
`default_nettype none
// ============================================================================
// Module      : switch_ddf_ms
// Description : Multi-stream dynamic-dataflow SWITCH actor. Each flux pairs
//               one data token with one control token. The data token,
//               tag unchanged, goes to output 0 or output 1 as control
//               payload bit 0 selects. A round-robin arbiter fires at most
//               one eligible flux per cycle.
// Ports       : clk, rst                   - clock, async active-high reset
//               in_port_*_data             - tagged data token input
//               in_port_*_ctrl             - tagged control token input
//               in_port_full_data/_ctrl    - per-flux FIFO full flags
//               out_port_write/dataout_0/1 - output token strobes / tokens
//               out_port_full_0/1          - downstream backpressure
// Revision    : 1.0 - initial release
// ============================================================================
module switch_ddf_ms
  import ddf_ms_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = $clog2(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_port_write_data,
  input  logic [WIDTH-1:0] in_port_datain_data,
  output logic [FLUX-1:0]  in_port_full_data,
  input  logic             in_port_write_ctrl,
  input  logic [WIDTH-1:0] in_port_datain_ctrl,
  output logic [FLUX-1:0]  in_port_full_ctrl,
  output logic             out_port_write_0,
  output logic [WIDTH-1:0] out_port_dataout_0,
  input  logic             out_port_full_0,
  output logic             out_port_write_1,
  output logic [WIDTH-1:0] out_port_dataout_1,
  input  logic             out_port_full_1
);

  localparam int C_TAG_MSB = tag_msb(DATA_WIDTH, TAG_WIDTH);
  localparam int C_TAG_LSB = tag_lsb(DATA_WIDTH);

  logic [TAG_WIDTH-1:0] w_tag_data;
  logic [TAG_WIDTH-1:0] w_tag_ctrl;
  logic [WIDTH-1:0]     w_data_head [FLUX];
  logic [WIDTH-1:0]     w_ctrl_head [FLUX];
  logic [FLUX-1:0]      w_data_empty;
  logic [FLUX-1:0]      w_ctrl_empty;
  logic [FLUX-1:0]      w_eligible;
  logic [FLUX-1:0]      w_pop;

  logic [TAG_WIDTH-1:0] r_rr;
  logic [TAG_WIDTH-1:0] w_grant;
  logic                 w_fire;
  logic                 w_sel;
  int                   w_idx;

  assign w_tag_data = in_port_datain_data[C_TAG_MSB:C_TAG_LSB];
  assign w_tag_ctrl = in_port_datain_ctrl[C_TAG_MSB:C_TAG_LSB];

  for (genvar t = 0; t < FLUX; t++) begin : g_flux
    ms_tag_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_data_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_port_write_data && (w_tag_data == TAG_WIDTH'(t))),
      .wr_data (in_port_datain_data),
      .full    (in_port_full_data[t]),
      .rd_en   (w_pop[t]),
      .rd_data (w_data_head[t]),
      .empty   (w_data_empty[t])
    );

    ms_tag_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_ctrl_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_port_write_ctrl && (w_tag_ctrl == TAG_WIDTH'(t))),
      .wr_data (in_port_datain_ctrl),
      .full    (in_port_full_ctrl[t]),
      .rd_en   (w_pop[t]),
      .rd_data (w_ctrl_head[t]),
      .empty   (w_ctrl_empty[t])
    );

    // A flux is only eligible if the output its head control token names
    // can accept, so a blocked output never stalls the other one.
    assign w_eligible[t] = !w_data_empty[t] && !w_ctrl_empty[t] &&
                           !(w_ctrl_head[t][C_SEL_BIT] ? out_port_full_1 : out_port_full_0);
    assign w_pop[t]      = w_fire && (w_grant == TAG_WIDTH'(t));
  end

  // Round-robin search starting at r_rr; the first eligible flux wins.
  always_comb begin
    w_fire  = 1'b0;
    w_grant = r_rr;
    w_idx   = 0;
    for (int i = 0; i < FLUX; i++) begin
      w_idx = int'(r_rr) + i;
      if (w_idx >= FLUX) w_idx = w_idx - FLUX;
      if (!w_fire && w_eligible[w_idx]) begin
        w_fire  = 1'b1;
        w_grant = TAG_WIDTH'(w_idx);
      end
    end
  end

  assign w_sel = w_ctrl_head[w_grant][C_SEL_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr               <= '0;
      out_port_write_0   <= 1'b0;
      out_port_write_1   <= 1'b0;
      out_port_dataout_0 <= '0;
      out_port_dataout_1 <= '0;
    end else begin
      out_port_write_0 <= 1'b0;
      out_port_write_1 <= 1'b0;
      if (w_fire) begin
        r_rr <= TAG_WIDTH'(rr_next(32'(w_grant), 32'(FLUX)));
        if (w_sel) begin
          out_port_write_1   <= 1'b1;
          out_port_dataout_1 <= w_data_head[w_grant];
        end else begin
          out_port_write_0   <= 1'b1;
          out_port_dataout_0 <= w_data_head[w_grant];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_ddf_ms.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_ddf_ms
// Description : Self-checking bench for switch_ddf_ms. Expected output
//               tokens are queued per output as stimulus is driven. A
//               negedge monitor pops and compares them whenever the DUT
//               strobes an output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_ddf_ms;

  localparam int FLUX  = 2;
  localparam int DW    = 8;
  localparam int TW    = 1;
  localparam int W     = DW + TW;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_port_write_data = 1'b0;
  logic [W-1:0]  in_port_datain_data = '0;
  logic [FLUX-1:0] in_port_full_data;
  logic          in_port_write_ctrl = 1'b0;
  logic [W-1:0]  in_port_datain_ctrl = '0;
  logic [FLUX-1:0] in_port_full_ctrl;
  logic          out_port_write_0;
  logic [W-1:0]  out_port_dataout_0;
  logic          out_port_full_0 = 1'b0;
  logic          out_port_write_1;
  logic [W-1:0]  out_port_dataout_1;
  logic          out_port_full_1 = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_out0 = 0;
  int n_out1 = 0;
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];

  always #5 clk = ~clk;

  switch_ddf_ms #(
    .FLUX       (FLUX),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_port_write_data  (in_port_write_data),
    .in_port_datain_data (in_port_datain_data),
    .in_port_full_data   (in_port_full_data),
    .in_port_write_ctrl  (in_port_write_ctrl),
    .in_port_datain_ctrl (in_port_datain_ctrl),
    .in_port_full_ctrl   (in_port_full_ctrl),
    .out_port_write_0    (out_port_write_0),
    .out_port_dataout_0  (out_port_dataout_0),
    .out_port_full_0     (out_port_full_0),
    .out_port_write_1    (out_port_write_1),
    .out_port_dataout_1  (out_port_dataout_1),
    .out_port_full_1     (out_port_full_1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every output strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_port_write_0) begin
      n_out0++;
      if (q0.size() == 0) check("out0_unexpected", 32'(out_port_dataout_0), 32'hFFFF_FFFF);
      else                check("out0_data", 32'(out_port_dataout_0), 32'(q0.pop_front()));
    end
    if (!rst && out_port_write_1) begin
      n_out1++;
      if (q1.size() == 0) check("out1_unexpected", 32'(out_port_dataout_1), 32'hFFFF_FFFF);
      else                check("out1_data", 32'(out_port_dataout_1), 32'(q1.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one data and/or control token for a single edge.
  task automatic put(input logic wd, input logic [W-1:0] d, input logic wc, input logic [W-1:0] c);
    in_port_write_data  = wd;
    in_port_datain_data = d;
    in_port_write_ctrl  = wc;
    in_port_datain_ctrl = c;
    tick();
    in_port_write_data = 1'b0;
    in_port_write_ctrl = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_w0"}, 32'(out_port_write_0), 32'd0);
    check({tag, "_w1"}, 32'(out_port_write_1), 32'd0);
  endtask

  initial begin
    int base;

    // 1: reset state, then idle after release
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    check_idle_outputs("rst");
    check("rst_d0", 32'(out_port_dataout_0), 32'd0);
    check("rst_d1", 32'(out_port_dataout_1), 32'd0);
    check("rst_full_data", 32'(in_port_full_data), 32'd0);
    check("rst_full_ctrl", 32'(in_port_full_ctrl), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick(2);
    @(negedge clk);
    check_idle_outputs("idle");

    // 2: minimum latency, routed to output 1
    @(posedge clk); #1;
    q1.push_back(9'h007);
    put(1'b1, 9'h007, 1'b1, 9'h001);
    @(negedge clk);
    check("lat_edge1_w1", 32'(out_port_write_1), 32'd0);
    @(negedge clk);
    check("lat_edge2_w1", 32'(out_port_write_1), 32'd1);
    check("lat_edge2_w0", 32'(out_port_write_0), 32'd0);
    @(negedge clk);
    check("lat_oneshot_w1", 32'(out_port_write_1), 32'd0);

    // Bring the round-robin pointer back to 0.
    @(posedge clk); #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;

    // 3: backpressure on output 0, then release
    out_port_full_0 = 1'b1;
    base = n_out0;
    q0.push_back(9'h003);
    q0.push_back(9'h104);
    put(1'b1, 9'h003, 1'b1, 9'h000);
    put(1'b1, 9'h104, 1'b1, 9'h100);
    tick(4);
    check("bp_blocked", 32'(n_out0), 32'(base));
    out_port_full_0 = 1'b0;
    @(negedge clk);
    check("bp_rel_c1", 32'(out_port_write_0), 32'd0);
    @(negedge clk);
    check("bp_rel_c2", 32'(out_port_write_0), 32'd1);
    @(negedge clk);
    check("bp_rel_c3", 32'(out_port_write_0), 32'd1);
    tick(2);
    check("bp_count", 32'(n_out0 - base), 32'd2);

    // 4: tag mismatch waits for its own partner
    base = n_out1;
    put(1'b1, 9'h105, 1'b1, 9'h000);
    tick(4);
    check("mismatch_wait", 32'(n_out1), 32'(base));
    q1.push_back(9'h105);
    put(1'b0, 9'h000, 1'b1, 9'h101);
    tick(3);
    check("mismatch_fire", 32'(n_out1 - base), 32'd1);
    // The leftover flux-0 control token (select 0) pairs with new data.
    q0.push_back(9'h009);
    put(1'b1, 9'h009, 1'b0, 9'h000);
    tick(3);
    check("ctrl_left_queued", 32'(q0.size()), 32'd0);

    // 5: fill data FIFO 0, drop a fifth write, then drain with 4 ctrl tokens
    for (int i = 0; i < DEPTH; i++) put(1'b1, W'(9'h010 + i), 1'b0, '0);
    @(negedge clk);
    check("full_data", 32'(in_port_full_data), 32'b01);
    check("full_ctrl", 32'(in_port_full_ctrl), 32'b00);
    @(posedge clk); #1;
    put(1'b1, 9'h014, 1'b0, '0);
    check("full_hold", 32'(in_port_full_data), 32'b01);
    base = n_out0 + n_out1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 2 == 0) q0.push_back(W'(9'h010 + i));
      else            q1.push_back(W'(9'h010 + i));
      put(1'b0, '0, 1'b1, W'(i % 2));
    end
    tick(8);
    check("drain_count", 32'(n_out0 + n_out1 - base), 32'd4);
    check("drain_empty", 32'(in_port_full_data), 32'b00);

    // 6: asynchronous reset mid-cycle with tokens queued and a write active
    out_port_full_0 = 1'b1;
    put(1'b1, 9'h020, 1'b1, 9'h000);
    put(1'b1, 9'h021, 1'b1, 9'h000);
    put(1'b1, 9'h122, 1'b1, 9'h101);
    @(posedge clk); #2;
    check("pre_rst_w1", 32'(out_port_write_1), 32'd1);
    check("pre_rst_d1", 32'(out_port_dataout_1), 32'h122);
    #1 rst = 1'b1;
    #1;
    check("async_rst_w1", 32'(out_port_write_1), 32'd0);
    check("async_rst_d1", 32'(out_port_dataout_1), 32'd0);
    check("async_rst_w0", 32'(out_port_write_0), 32'd0);
    tick(2);
    rst = 1'b0;
    out_port_full_0 = 1'b0;
    base = n_out0 + n_out1;
    tick(10);
    check("post_rst_silent", 32'(n_out0 + n_out1), 32'(base));

    check("sb_q0_empty", 32'(q0.size()), 32'd0);
    check("sb_q1_empty", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
